alu_result_collector: RTL

//  Downstream stage of the ALU: captures every result C qualified by C_en.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_sat_acc.sv | 64 ++++++
 rtl/alu_result_collector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result path.
//   C_W            : width of an ALU result
//   ACC_W_DEFAULT  : default width of the running-sum accumulator
//   alu_result_t   : signed ALU result, ascending range, bit 0 is the MSB
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int C_W           = 6;
    localparam int ACC_W_DEFAULT = 12;

    typedef logic signed [0:C_W-1] alu_result_t;

endpackage : alu_pkg

// File: rtl/alu_sat_acc.sv
// ---------------------------------------------------------------------------
// alu_sat_acc
// Saturating signed accumulator with clear and load.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear request (alone -> 0, with add_en -> load din)
//   add_en     : add din into the running sum this cycle
//   din        : sign-extended addend (ACC_W bits, two's complement)
//   acc        : registered running sum, clamped to the signed ACC_W range
// ---------------------------------------------------------------------------
module alu_sat_acc #(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W:0]   sum_s;

    // Clamp a one-bit-wider sum back into ACC_W bits. The two top bits differ
    // only when the true result left the representable range; the extra top
    // bit then gives the direction of the overflow.
    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] s);
        logic [ACC_W-1:0] r;
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W]) begin
                r = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                r = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            r = s[ACC_W-1:0];
        end
        return r;
    endfunction

    // Sign-extended add: one guard bit catches overflow in either direction.
    assign sum_s = {acc_r[ACC_W-1], acc_r} + {din[ACC_W-1], din};

    // Accumulator register: load wins over add when clear and add coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (add_en) begin
            if (clr) begin
                acc_r <= din;
            end else begin
                acc_r <= sat(sum_s);
            end
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule : alu_sat_acc

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
// Captures every ALU result qualified by C_en into a DEPTH-entry FIFO,
// presents the head on a valid/ready stream and keeps a saturating signed
// running sum of every accepted result.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   C_en, C         : ALU result strobe and signed result (bit 0 = MSB)
//   out_valid/ready : output handshake; out_data is the FIFO head
//   count           : occupancy 0..DEPTH; full / empty derived from it
//   overflow        : sticky, a result was dropped because the FIFO was full
//   ovf_clr         : clears overflow (a same-cycle drop takes priority)
//   acc_clr         : clears the accumulator (loads C if a push coincides)
//   acc             : saturating signed sum of accepted results
// All outputs come straight from flops; there is no path from C to out_data.
// ---------------------------------------------------------------------------
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       C_en,
    input  alu_result_t                C,
    output logic                       out_valid,
    input  logic                       out_ready,
    output alu_result_t                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr,
    input  logic                       acc_clr,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_result_t       mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              empty_r;
    logic              full_r;
    logic              valid_r;
    logic              ovf_r;
    alu_result_t       data_r;

    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [CNT_W-1:0]  count_next_s;
    alu_result_t       data_next_s;
    logic [ACC_W-1:0]  c_ext_s;
    logic [ACC_W-1:0]  acc_s;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop_s         = valid_r && out_ready;
    assign push_s        = C_en && (!full_r || pop_s);
    assign drop_s        = C_en && full_r && !pop_s;
    assign rd_ptr_next_s = rd_ptr_r + PTR_W'(1);

    // C is declared MSB-first, so concatenation keeps C[0] as the sign bit.
    assign c_ext_s = {{(ACC_W-C_W){C[0]}}, C};

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Next head value. out_data is a register, so the entry behind the head
    // is fetched one cycle early; when the FIFO holds at most the head, the
    // incoming result becomes the new head directly.
    always_comb begin
        data_next_s = data_r;
        if (pop_s) begin
            if (count_r == CNT_W'(1)) begin
                if (push_s) begin
                    data_next_s = C;
                end else begin
                    data_next_s = data_r;
                end
            end else begin
                data_next_s = mem_r[rd_ptr_next_s];
            end
        end else if (push_s && empty_r) begin
            data_next_s = C;
        end else begin
            data_next_s = data_r;
        end
    end

    // FIFO storage: contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= C;
        end
    end

    // Pointers, occupancy, flags, head register and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= {C_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_next_s;
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CNT_W{1'b0}});
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            valid_r <= (count_next_s != {CNT_W{1'b0}});
            data_r  <= data_next_s;
            // A drop in the same cycle as the clear leaves the flag set.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    alu_sat_acc #(
        .ACC_W (ACC_W)
    ) u_sat_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .add_en (push_s),
        .din    (c_ext_s),
        .acc    (acc_s)
    );

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign overflow  = ovf_r;
    assign acc       = acc_s;

endmodule : alu_result_collector
